ccu_snoop_arbiter: RTL and testbench
====================================

// Module: ccu_snoop_arbiter
// PURPOSE
//  Shares the single CCU snoop master port (AC/CR/CD toward the snoop crossbar) between the
//  read-snoop controller (requester 0) and the write-snoop controller (requester 1).
//  Round-robin arbitration on AC; in-order routing of CR and CD back to the issuing requester
//  through two order FIFOs. Zero-latency combinational datapath; state lives only in arbitration
//  and ordering.
// PARAMETERS
//  ADDR_WIDTH       64  AC address width
//  DATA_WIDTH       64  CD data width
//  MAX_OUTSTANDING  4   max AC issued without a CR returned; also CD order FIFO depth (>=1)
// PORTS
//  clk_i           in   1            clock
//  rst_ni          in   1            reset, asynchronous, active-low
//  req_ac_valid_i  in   2            per-requester AC valid
//  req_ac_ready_o  out  2            per-requester AC ready
//  req_ac_addr_i   in   2*ADDR_WIDTH AC address, [r*ADDR_WIDTH +: ADDR_WIDTH]
//  req_ac_snoop_i  in   2*4          ACSNOOP per requester
//  req_ac_prot_i   in   2*3          ACPROT per requester
//  req_cr_valid_o  out  2            CR valid routed to requester
//  req_cr_ready_i  in   2            CR ready from requester
//  req_cr_resp_o   out  5            CRRESP broadcast: [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique
//  req_cd_valid_o  out  2            CD valid routed to requester
//  req_cd_ready_i  in   2            CD ready from requester
//  req_cd_data_o   out  DATA_WIDTH   CD data broadcast
//  req_cd_last_o   out  1            CD last broadcast
//  ac_valid_o      out  1            AC valid to crossbar
//  ac_ready_i      in   1            AC ready from crossbar
//  ac_addr_o / ac_snoop_o / ac_prot_o   out  ADDR_WIDTH/4/3  granted AC payload
//  cr_valid_i      in   1            CR valid;  cr_ready_o  out  1  CR ready;  cr_resp_i  in  5
//  cd_valid_i      in   1            CD valid;  cd_ready_o  out  1  CD ready
//  cd_data_i       in   DATA_WIDTH   CD data;   cd_last_i   in   1  CD last
//  outstanding_o   out  $clog2(MAX_OUTSTANDING+1)  CR order FIFO occupancy
//  spurious_o      out  1            sticky: cr_valid_i or cd_valid_i seen while matching order FIFO empty
// BEHAVIOUR
//  Reset: all valid/ready outputs 0; priority pointer = requester 0; both FIFOs empty;
//   outstanding_o = 0; spurious_o = 0. Reset mid-transfer drops all ordering state.
//  AC arbitration:
//   - Grant is the valid requester nearest the priority pointer (pointer first).
//   - Grant is locked while ac_valid_o && !ac_ready_i; payload and grant are held stable.
//   - ac_valid_o = (any req valid) && !cr_fifo_full.
//   - req_ac_ready_o[g] = ac_ready_i && !cr_fifo_full, only for the granted g; 0 for the other.
//   - On AC handshake: push g into the CR order FIFO; pointer <= ~g.
//   - A full FIFO blocks AC even if a CR pops in the same cycle (no bypass).
//  CR routing (head h of CR FIFO):
//   - req_cr_valid_o[h] = cr_valid_i && cr_fifo_nonempty.
//   - cr_ready_o = req_cr_ready_i[h] && cr_fifo_nonempty && !(cr_resp_i[0] && cd_fifo_full).
//   - On handshake: pop h; if DataTransfer=1, push h into the CD order FIFO.
//   - CR FIFO: same-cycle push and pop allowed, occupancy unchanged.
//  CD routing (head k of CD FIFO):
//   - req_cd_valid_o[k] = cd_valid_i && cd_fifo_nonempty.
//   - cd_ready_o = req_cd_ready_i[k] && cd_fifo_nonempty.
//   - Pop k on a handshake with cd_last_i=1. CD FIFO: same-cycle push and pop allowed.
//   - CD may precede its CR; it waits (cd_ready_o=0) until its CR is accepted.
//  Latency: AC, CR and CD paths are zero-cycle combinational; no payload registering.
//  outstanding_o counts 0..MAX_OUTSTANDING and never wraps.
//  spurious_o: set when cr_valid_i arrives with the CR FIFO empty, or when cd_valid_i arrives
//   with the CD FIFO empty and no CR handshake with DataTransfer=1 in that cycle. Cleared only
//   by reset.
// TESTING
//  Both req valid every cycle, ac_ready_i=1 -> grants alternate 0,1,0,1; outstanding_o climbs
//   to 4; ac_valid_o=0 until a CR pops.
//  Req1 valid, ac_ready_i=0 for 3 cycles, req0 raised in cycle 2 -> grant stays 1 and the
//   addr_o/snoop_o/prot_o values presented in cycle 1 are unchanged until the handshake.
//  Issue r0,r1; CR resp 5'b00001 then 5'b00000 -> first CR routed to req0 with CD (4 beats,
//   last on beat 4) routed to req0; second CR routed to req1 with no CD.
//  cd_valid_i asserted 2 cycles before its CR -> cd_ready_o=0 until the CR handshake, then
//   beats go to the correct requester.
//  MAX_OUTSTANDING=1, AC held while the FIFO is full and the CR pops in the same cycle ->
//   AC is accepted the next cycle, not in the pop cycle.
//  cr_valid_i with no outstanding AC -> spurious_o=1 held; assert rst_ni mid-CD -> all
//   outputs 0, spurious_o=0.

Source files
------------

// File: rtl/ccu_snoop_arbiter.sv
// Snoop master port sharing between the read-snoop (0) and write-snoop (1)
// controllers: round-robin AC arbitration, in-order CR/CD return routing.
module ccu_snoop_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [1:0]                             req_ac_valid_i,
  output logic [1:0]                             req_ac_ready_o,
  input  logic [2*ADDR_WIDTH-1:0]                req_ac_addr_i,
  input  logic [7:0]                             req_ac_snoop_i,
  input  logic [5:0]                             req_ac_prot_i,
  output logic [1:0]                             req_cr_valid_o,
  input  logic [1:0]                             req_cr_ready_i,
  output logic [4:0]                             req_cr_resp_o,
  output logic [1:0]                             req_cd_valid_o,
  input  logic [1:0]                             req_cd_ready_i,
  output logic [DATA_WIDTH-1:0]                  req_cd_data_o,
  output logic                                   req_cd_last_o,
  output logic                                   ac_valid_o,
  input  logic                                   ac_ready_i,
  output logic [ADDR_WIDTH-1:0]                  ac_addr_o,
  output logic [3:0]                             ac_snoop_o,
  output logic [2:0]                             ac_prot_o,
  input  logic                                   cr_valid_i,
  output logic                                   cr_ready_o,
  input  logic [4:0]                             cr_resp_i,
  input  logic                                   cd_valid_i,
  output logic                                   cd_ready_o,
  input  logic [DATA_WIDTH-1:0]                  cd_data_i,
  input  logic                                   cd_last_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   spurious_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ARB_FREE    = 2'd0,
    ARB_HOLD_R0 = 2'd1,
    ARB_HOLD_R1 = 2'd2
  } arb_state_e;

  arb_state_e arb_state_q, arb_state_d;
  logic       prio_q;
  logic       grant;
  logic       ac_hs;

  logic [MAX_OUTSTANDING-1:0] cr_mem_q, cd_mem_q;
  logic [PTR_W-1:0]           cr_wr_q, cr_rd_q, cd_wr_q, cd_rd_q;
  logic [CNT_W-1:0]           cr_cnt_q, cd_cnt_q;
  logic                       cr_full, cr_nonempty, cd_full, cd_nonempty;
  logic                       cr_head, cd_head;
  logic                       cr_hs, cd_push, cd_pop;
  logic                       spurious_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  assign cr_nonempty = (cr_cnt_q != '0);
  assign cr_full     = (cr_cnt_q == FULL_CNT);
  assign cd_nonempty = (cd_cnt_q != '0);
  assign cd_full     = (cd_cnt_q == FULL_CNT);
  assign cr_head     = cr_mem_q[cr_rd_q];
  assign cd_head     = cd_mem_q[cd_rd_q];

  // Grant selection and lock: a stalled AC keeps its requester until accepted.
  always_comb begin
    arb_state_d = ARB_FREE;
    grant       = prio_q;
    case (arb_state_q)
      ARB_HOLD_R0: grant = 1'b0;
      ARB_HOLD_R1: grant = 1'b1;
      default:     grant = req_ac_valid_i[prio_q] ? prio_q : ~prio_q;
    endcase
    if (ac_valid_o && !ac_ready_i) begin
      arb_state_d = grant ? ARB_HOLD_R1 : ARB_HOLD_R0;
    end
  end

  // Arbitration state and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arb_state_q <= ARB_FREE;
      prio_q      <= 1'b0;
    end else begin
      arb_state_q <= arb_state_d;
      if (ac_hs) begin
        prio_q <= ~grant;
      end
    end
  end

  assign ac_valid_o = rst_ni && (|req_ac_valid_i) && !cr_full;
  assign ac_hs      = ac_valid_o && ac_ready_i;
  assign ac_addr_o  = grant ? req_ac_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_ac_addr_i[ADDR_WIDTH-1:0];
  assign ac_snoop_o = grant ? req_ac_snoop_i[7:4] : req_ac_snoop_i[3:0];
  assign ac_prot_o  = grant ? req_ac_prot_i[5:3] : req_ac_prot_i[2:0];

  // AC ready goes back only to the granted requester.
  always_comb begin
    req_ac_ready_o = 2'b00;
    if (rst_ni && ac_ready_i && !cr_full) begin
      req_ac_ready_o[grant] = 1'b1;
    end
  end

  assign cr_ready_o    = req_cr_ready_i[cr_head] && cr_nonempty && !(cr_resp_i[0] && cd_full);
  assign cr_hs         = cr_valid_i && cr_ready_o;
  assign cd_push       = cr_hs && cr_resp_i[0];
  assign req_cr_resp_o = cr_resp_i;

  // CR valid routed to the requester at the head of the CR order FIFO.
  always_comb begin
    req_cr_valid_o          = 2'b00;
    req_cr_valid_o[cr_head] = cr_valid_i && cr_nonempty;
  end

  assign cd_ready_o    = req_cd_ready_i[cd_head] && cd_nonempty;
  assign cd_pop        = cd_valid_i && cd_ready_o && cd_last_i;
  assign req_cd_data_o = cd_data_i;
  assign req_cd_last_o = cd_last_i;

  // CD valid routed to the requester whose data-carrying CR is oldest.
  always_comb begin
    req_cd_valid_o          = 2'b00;
    req_cd_valid_o[cd_head] = cd_valid_i && cd_nonempty;
  end

  // CR order FIFO: one entry per accepted AC, retired by its CR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cr_mem_q <= '0;
      cr_wr_q  <= '0;
      cr_rd_q  <= '0;
      cr_cnt_q <= '0;
    end else begin
      if (ac_hs) begin
        cr_mem_q[cr_wr_q] <= grant;
        cr_wr_q           <= next_ptr(cr_wr_q);
      end
      if (cr_hs) begin
        cr_rd_q <= next_ptr(cr_rd_q);
      end
      if (ac_hs && !cr_hs) begin
        cr_cnt_q <= cr_cnt_q + CNT_W'(1);
      end else if (!ac_hs && cr_hs) begin
        cr_cnt_q <= cr_cnt_q - CNT_W'(1);
      end
    end
  end

  // CD order FIFO: one entry per CR with DataTransfer, retired by its last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cd_mem_q <= '0;
      cd_wr_q  <= '0;
      cd_rd_q  <= '0;
      cd_cnt_q <= '0;
    end else begin
      if (cd_push) begin
        cd_mem_q[cd_wr_q] <= cr_head;
        cd_wr_q           <= next_ptr(cd_wr_q);
      end
      if (cd_pop) begin
        cd_rd_q <= next_ptr(cd_rd_q);
      end
      if (cd_push && !cd_pop) begin
        cd_cnt_q <= cd_cnt_q + CNT_W'(1);
      end else if (!cd_push && cd_pop) begin
        cd_cnt_q <= cd_cnt_q - CNT_W'(1);
      end
    end
  end

  // Sticky flag for CR/CD traffic that has no matching ordering entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spurious_q <= 1'b0;
    end else if ((cr_valid_i && !cr_nonempty) || (cd_valid_i && !cd_nonempty && !cd_push)) begin
      spurious_q <= 1'b1;
    end
  end

  assign outstanding_o = cr_cnt_q;
  assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Scoreboard bench for ccu_snoop_arbiter: directed scenarios plus random traffic,
// checked by a monitor against a queue-based reference of the ordering rules.
module tb_ccu_snoop_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [1:0]      req_ac_valid_i, req_ac_ready_o;
  logic [2*AW-1:0] req_ac_addr_i;
  logic [7:0]      req_ac_snoop_i;
  logic [5:0]      req_ac_prot_i;
  logic [1:0]      req_cr_valid_o, req_cr_ready_i;
  logic [4:0]      req_cr_resp_o;
  logic [1:0]      req_cd_valid_o, req_cd_ready_i;
  logic [DW-1:0]   req_cd_data_o;
  logic            req_cd_last_o;
  logic            ac_valid_o, ac_ready_i;
  logic [AW-1:0]   ac_addr_o;
  logic [3:0]      ac_snoop_o;
  logic [2:0]      ac_prot_o;
  logic            cr_valid_i, cr_ready_o;
  logic [4:0]      cr_resp_i;
  logic            cd_valid_i, cd_ready_o;
  logic [DW-1:0]   cd_data_i;
  logic            cd_last_i;
  logic [2:0]      outstanding_o;
  logic            spurious_o;

  ccu_snoop_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_ac_valid_i(req_ac_valid_i), .req_ac_ready_o(req_ac_ready_o),
    .req_ac_addr_i(req_ac_addr_i), .req_ac_snoop_i(req_ac_snoop_i), .req_ac_prot_i(req_ac_prot_i),
    .req_cr_valid_o(req_cr_valid_o), .req_cr_ready_i(req_cr_ready_i), .req_cr_resp_o(req_cr_resp_o),
    .req_cd_valid_o(req_cd_valid_o), .req_cd_ready_i(req_cd_ready_i),
    .req_cd_data_o(req_cd_data_o), .req_cd_last_o(req_cd_last_o),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
    .outstanding_o(outstanding_o), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  int n_compared = 0;
  int n_failed   = 0;

  // Scoreboard queues filled by stimulus: expected payloads per requester, CR responses, CD beats.
  logic [70:0] exp_ac_q0[$];
  logic [70:0] exp_ac_q1[$];
  logic [4:0]  exp_cr_q[$];
  logic [64:0] exp_cd_q[$];

  // Reference model: issue order of outstanding snoops and of pending data transfers.
  bit   mo_q[$];
  bit   mcd_q[$];
  bit   m_ptr, m_lock, m_lock_g, m_spur;
  bit   m_g, m_h, m_k, cr_ne, cd_ne, exp_acv, exp_crr, exp_cdr, m_ac_hs, m_cr_hs, m_cd_hs;
  logic [70:0] pay;
  logic [64:0] cdx;
  logic [4:0]  rx;

  // Handshakes observed on the DUT, used only by the random driver to pace traffic.
  logic [1:0] hs_ac;
  logic       hs_cr, hs_cd;
  int         mon_ac_cnt, mon_dt_cnt;

  function automatic logic [1:0] oh(input bit r);
    return r ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sbEmpty(input string name);
    n_compared++;
    n_failed++;
    $display("[TB] FAIL %s: scoreboard queue empty at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic raise_ac(input int r);
    logic [70:0] p;
    p = {$urandom, $urandom, 7'($urandom)};
    if (r == 0) begin
      req_ac_addr_i[AW-1:0] = p[70:7];
      req_ac_snoop_i[3:0]   = p[6:3];
      req_ac_prot_i[2:0]    = p[2:0];
      exp_ac_q0.push_back(p);
    end else begin
      req_ac_addr_i[2*AW-1:AW] = p[70:7];
      req_ac_snoop_i[7:4]      = p[6:3];
      req_ac_prot_i[5:3]       = p[2:0];
      exp_ac_q1.push_back(p);
    end
    req_ac_valid_i[r] = 1'b1;
  endtask

  task automatic issue_cr(input logic [4:0] resp);
    cr_valid_i = 1'b1;
    cr_resp_i  = resp;
    exp_cr_q.push_back(resp);
  endtask

  task automatic drive_cd_beat(input logic last);
    cd_data_i  = {$urandom, $urandom};
    cd_last_i  = last;
    cd_valid_i = 1'b1;
    exp_cd_q.push_back({last, cd_data_i});
  endtask

  task automatic idle_inputs();
    req_ac_valid_i = '0; req_ac_addr_i = '0; req_ac_snoop_i = '0; req_ac_prot_i = '0;
    req_cr_ready_i = '0; req_cd_ready_i = '0; ac_ready_i = 1'b0;
    cr_valid_i = 1'b0; cr_resp_i = '0; cd_valid_i = 1'b0; cd_data_i = '0; cd_last_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    exp_ac_q0.delete(); exp_ac_q1.delete(); exp_cr_q.delete(); exp_cd_q.delete();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ac_valid"}, ac_valid_o, 0);
    checkOutput({tag, "_req_ac_ready"}, req_ac_ready_o, 0);
    checkOutput({tag, "_cr_ready"}, cr_ready_o, 0);
    checkOutput({tag, "_cd_ready"}, cd_ready_o, 0);
    checkOutput({tag, "_req_cr_valid"}, req_cr_valid_o, 0);
    checkOutput({tag, "_req_cd_valid"}, req_cd_valid_o, 0);
    checkOutput({tag, "_outstanding"}, outstanding_o, 0);
    checkOutput({tag, "_spurious"}, spurious_o, 0);
  endtask

  // Monitor: every mid-cycle, compare all routed outputs with the model, then advance it.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mo_q.delete(); mcd_q.delete();
      m_ptr = 0; m_lock = 0; m_lock_g = 0; m_spur = 0;
      hs_ac = '0; hs_cr = 0; hs_cd = 0; mon_ac_cnt = 0; mon_dt_cnt = 0;
    end else begin
      hs_ac = req_ac_valid_i & req_ac_ready_o;
      hs_cr = cr_valid_i && cr_ready_o;
      hs_cd = cd_valid_i && cd_ready_o;
      if (ac_valid_o && ac_ready_i) mon_ac_cnt++;
      if (hs_cr && cr_resp_i[0]) mon_dt_cnt++;

      exp_acv = (|req_ac_valid_i) && (mo_q.size() < MAXO);
      m_g = m_lock ? m_lock_g : (req_ac_valid_i[m_ptr] ? m_ptr : !m_ptr);
      checkOutput("ac_valid", ac_valid_o, exp_acv);
      if (mo_q.size() >= MAXO) checkOutput("ac_ready_full", req_ac_ready_o, 0);
      if (exp_acv) begin
        checkOutput("req_ac_ready", req_ac_ready_o, ac_ready_i ? oh(m_g) : 2'b00);
        if ((m_g ? exp_ac_q1.size() : exp_ac_q0.size()) == 0) sbEmpty("ac_payload");
        else begin
          pay = m_g ? exp_ac_q1[0] : exp_ac_q0[0];
          checkOutput("ac_payload", {ac_addr_o, ac_snoop_o, ac_prot_o}, pay);
        end
      end
      m_ac_hs = exp_acv && ac_ready_i;

      cr_ne   = (mo_q.size() != 0);
      m_h     = cr_ne ? mo_q[0] : 1'b0;
      exp_crr = cr_ne && req_cr_ready_i[m_h] && !(cr_resp_i[0] && mcd_q.size() == MAXO);
      checkOutput("req_cr_valid", req_cr_valid_o, (cr_valid_i && cr_ne) ? oh(m_h) : 2'b00);
      checkOutput("cr_ready", cr_ready_o, exp_crr);
      m_cr_hs = cr_valid_i && exp_crr;
      if (m_cr_hs) begin
        if (exp_cr_q.size() == 0) sbEmpty("cr_resp");
        else begin
          rx = exp_cr_q.pop_front();
          checkOutput("cr_resp", req_cr_resp_o, rx);
        end
      end

      cd_ne   = (mcd_q.size() != 0);
      m_k     = cd_ne ? mcd_q[0] : 1'b0;
      exp_cdr = cd_ne && req_cd_ready_i[m_k];
      checkOutput("req_cd_valid", req_cd_valid_o, (cd_valid_i && cd_ne) ? oh(m_k) : 2'b00);
      checkOutput("cd_ready", cd_ready_o, exp_cdr);
      m_cd_hs = cd_valid_i && exp_cdr;
      if (m_cd_hs) begin
        if (exp_cd_q.size() == 0) sbEmpty("cd_beat");
        else begin
          cdx = exp_cd_q.pop_front();
          checkOutput("cd_beat", {req_cd_last_o, req_cd_data_o}, cdx);
        end
      end

      checkOutput("outstanding", outstanding_o, mo_q.size());
      checkOutput("spurious", spurious_o, m_spur);

      m_spur = m_spur || (cr_valid_i && !cr_ne) ||
               (cd_valid_i && !cd_ne && !(m_cr_hs && cr_resp_i[0]));
      if (m_cd_hs && cd_last_i) void'(mcd_q.pop_front());
      if (m_cr_hs) begin
        if (cr_resp_i[0]) mcd_q.push_back(m_h);
        void'(mo_q.pop_front());
      end
      if (m_ac_hs) begin
        if (m_g) void'(exp_ac_q1.pop_front()); else void'(exp_ac_q0.pop_front());
        mo_q.push_back(m_g);
        m_ptr = !m_g;
      end
      m_lock   = exp_acv && !ac_ready_i;
      m_lock_g = m_g;
    end
  end

  // Random traffic obeying valid/ready rules; CR and CD only when owed.
  task automatic applyStimulus(input int cycles);
    int cr_issued = 0;
    int bursts = 0;
    int beats_left = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        if (req_ac_valid_i[r] && hs_ac[r]) req_ac_valid_i[r] = 1'b0;
        if (!req_ac_valid_i[r] && $urandom_range(0, 2) != 0) raise_ac(r);
      end
      ac_ready_i = ($urandom_range(0, 3) != 0);
      if (cr_valid_i && hs_cr) cr_valid_i = 1'b0;
      if (!cr_valid_i && mon_ac_cnt > cr_issued && $urandom_range(0, 2) != 0) begin
        issue_cr(5'($urandom));
        cr_issued++;
      end
      req_cr_ready_i = 2'($urandom);
      req_cd_ready_i = 2'($urandom);
      if (cd_valid_i && hs_cd) begin
        beats_left--;
        if (beats_left == 0) cd_valid_i = 1'b0;
        else drive_cd_beat(beats_left == 1);
      end
      if (!cd_valid_i && mon_dt_cnt > bursts && $urandom_range(0, 1) != 0) begin
        beats_left = $urandom_range(1, 4);
        bursts++;
        drive_cd_beat(beats_left == 1);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    req_ac_valid_i = 2'b11; ac_ready_i = 1'b1; cr_valid_i = 1'b1; cd_valid_i = 1'b1;
    req_cr_ready_i = 2'b11; req_cd_ready_i = 2'b11;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    do_reset();

    // Both requesters always valid: grants alternate until the order FIFO is full.
    raise_ac(0); raise_ac(1); ac_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("grant_alt", req_ac_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput("outstanding_climb", outstanding_o, i);
      step();
      raise_ac(i % 2);
    end
    @(negedge clk_i);
    checkOutput("full_ac_valid", ac_valid_o, 0);
    checkOutput("full_outstanding", outstanding_o, 4);

    // CR pops while full: AC stays blocked that cycle, accepted the next.
    step();
    issue_cr(5'b00000); req_cr_ready_i = 2'b11;
    @(negedge clk_i);
    checkOutput("pop_cycle_cr_ready", cr_ready_o, 1);
    checkOutput("pop_cycle_ac_blocked", ac_valid_o, 0);
    step();
    cr_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("after_pop_ac_valid", ac_valid_o, 1);
    checkOutput("after_pop_grant", req_ac_ready_o, 2'b01);
    do_reset();

    // Grant locked on requester 1 while AC is stalled, despite requester 0 having priority.
    raise_ac(1);
    pay = {req_ac_addr_i[2*AW-1:AW], req_ac_snoop_i[7:4], req_ac_prot_i[5:3]};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("lock_payload", {ac_addr_o, ac_snoop_o, ac_prot_o}, pay);
      step();
      if (i == 0) raise_ac(0);
      if (i == 2) ac_ready_i = 1'b1;
    end
    @(negedge clk_i);
    checkOutput("lock_release_grant", req_ac_ready_o, 2'b10);
    checkOutput("lock_release_payload", {ac_addr_o, ac_snoop_o, ac_prot_o}, pay);
    step();
    raise_ac(1);
    @(negedge clk_i);
    checkOutput("post_lock_rr", req_ac_ready_o, 2'b01);
    do_reset();

    // Issue r0 then r1; CD arrives early; CR with data to r0, CR without data to r1.
    raise_ac(0); ac_ready_i = 1'b1;
    step();
    req_ac_valid_i[0] = 1'b0; raise_ac(1);
    step();
    req_ac_valid_i[1] = 1'b0; ac_ready_i = 1'b0;
    drive_cd_beat(1'b0); req_cd_ready_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput("cd_early_ready", cd_ready_o, 0);
      step();
    end
    issue_cr(5'b00001); req_cr_ready_i = 2'b11;
    @(negedge clk_i);
    checkOutput("cr0_route", req_cr_valid_o, 2'b01);
    checkOutput("cr0_cd_wait", cd_ready_o, 0);
    step();
    issue_cr(5'b00000);
    @(negedge clk_i);
    checkOutput("cr1_route", req_cr_valid_o, 2'b10);
    checkOutput("cd_beat0_route", req_cd_valid_o, 2'b01);
    for (int b = 1; b < 4; b++) begin
      step();
      cr_valid_i = 1'b0;
      drive_cd_beat(b == 3);
      @(negedge clk_i);
      checkOutput("cd_beat_route", req_cd_valid_o, 2'b01);
    end
    step();
    cd_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("drained_outstanding", outstanding_o, 0);
    checkOutput("early_cd_spurious", spurious_o, 1);
    do_reset();

    // CR with nothing outstanding, then reset in the middle of a CD burst.
    cr_valid_i = 1'b1; req_cr_ready_i = 2'b11;
    @(negedge clk_i);
    checkOutput("orphan_cr_route", req_cr_valid_o, 2'b00);
    step();
    cr_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput("spurious_sticky", spurious_o, 1);
      step();
    end
    raise_ac(0); ac_ready_i = 1'b1;
    step();
    req_ac_valid_i[0] = 1'b0; issue_cr(5'b00001);
    step();
    cr_valid_i = 1'b0; drive_cd_beat(1'b0); req_cd_ready_i = 2'b11;
    @(negedge clk_i);
    checkOutput("mid_cd_route", req_cd_valid_o, 2'b01);
    step();
    drive_cd_beat(1'b0); raise_ac(0); raise_ac(1);
    rst_ni = 1'b0;
    #2;
    check_all_zero("mid_reset");
    do_reset();

    applyStimulus(3000);
    idle_inputs();
    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
